// File: rtl/next_pc_unit.sv
// next_pc_unit: branch/jump resolution stage with a valid/ready request side
// and a registered valid/ready response side.
// Optional return-address stack: define NEXT_PC_RAS_EN to build it.
// Without NEXT_PC_RAS_EN the register-indirect jump always goes to reg_target
// and both RAS error flags are tied low.
module next_pc_unit #(
  parameter int PC_W      = 8,
  parameter int IMM_W     = 16,
  parameter int RAS_DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [PC_W-1:0]  pc,
  input  logic [PC_W-1:0]  address,
  input  logic [PC_W-1:0]  reg_target,
  input  logic [5:0]       opcode,
  input  logic [31:0]      result,
  input  logic [IMM_W-1:0] imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [PC_W-1:0]  new_pc,
  output logic             taken,
  output logic [PC_W-1:0]  link_pc,
  output logic             link_we,
  output logic             ras_overflow,
  output logic             ras_underflow
);

  localparam logic [5:0] OpBnzBack = 6'b001110;
  localparam logic [5:0] OpBnzFwd  = 6'b001111;
  localparam logic [5:0] OpBzA     = 6'b010000;
  localparam logic [5:0] OpBzB     = 6'b010001;
  localparam logic [5:0] OpBoneA   = 6'b010010;
  localparam logic [5:0] OpBoneB   = 6'b010011;
  localparam logic [5:0] OpJump    = 6'b010100;
  localparam logic [5:0] OpJumpReg = 6'b010101;
  localparam logic [5:0] OpCall    = 6'b010110;

  // A depth below two makes the stack pointer zero bits wide; this empty
  // labelled block flags such a configuration in the elaborated hierarchy.
  if (RAS_DEPTH < 2) begin : g_rasDepthTooSmall
  end

  logic                     r_outValid;
  logic [PC_W-1:0]          r_newPc;
  logic                     r_taken;
  logic [PC_W-1:0]          r_linkPc;
  logic                     r_linkWe;

  logic                     w_accept;
  logic [PC_W-1:0]          w_seq;
  logic [PC_W+IMM_W-1:0]    w_immExt;
  logic [PC_W-1:0]          w_immPc;
  logic [PC_W-1:0]          w_retTarget;
  logic [PC_W-1:0]          w_nextPc;
  logic                     w_taken;
  logic [PC_W-1:0]          w_linkPc;
  logic                     w_linkWe;

  assign in_ready = !r_outValid || out_ready;
  assign w_accept = in_valid && in_ready;
  assign w_seq    = pc + 1'b1;
  assign w_immExt = {{PC_W{1'b0}}, imm};
  assign w_immPc  = w_immExt[PC_W-1:0];

`ifdef NEXT_PC_RAS_EN
  localparam int RasPtrW = $clog2(RAS_DEPTH);
  localparam int RasCntW = RasPtrW + 1;
  localparam logic [RasCntW-1:0] RasFull = RasCntW'(RAS_DEPTH);

  logic [PC_W-1:0]    r_rasMem [RAS_DEPTH];
  logic [RasPtrW-1:0] r_rasPtr;
  logic [RasCntW-1:0] r_rasCount;
  logic               r_rasOverflow;
  logic               r_rasUnderflow;
  logic [RasPtrW-1:0] w_rasTopIdx;
  logic               w_isCall;
  logic               w_isRet;

  assign w_isCall    = (opcode == OpCall);
  assign w_isRet     = (opcode == OpJumpReg);
  assign w_rasTopIdx = r_rasPtr - 1'b1;
  assign w_retTarget = (r_rasCount == '0) ? reg_target : r_rasMem[w_rasTopIdx];

  // Stack bookkeeping: a call on a full stack wraps onto the oldest slot, a
  // return on an empty stack leaves the pointer alone; both set sticky flags.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rasPtr       <= '0;
      r_rasCount     <= '0;
      r_rasOverflow  <= 1'b0;
      r_rasUnderflow <= 1'b0;
    end else if (w_accept && w_isCall) begin
      r_rasPtr <= r_rasPtr + 1'b1;
      if (r_rasCount == RasFull) r_rasOverflow <= 1'b1;
      else                       r_rasCount    <= r_rasCount + 1'b1;
    end else if (w_accept && w_isRet) begin
      if (r_rasCount == '0) begin
        r_rasUnderflow <= 1'b1;
      end else begin
        r_rasPtr   <= r_rasPtr - 1'b1;
        r_rasCount <= r_rasCount - 1'b1;
      end
    end
  end

  // Return-address storage; emptiness is tracked by the count, so no reset.
  always_ff @(posedge clk) begin
    if (w_accept && w_isCall) r_rasMem[r_rasPtr] <= w_seq;
  end

  assign ras_overflow  = r_rasOverflow;
  assign ras_underflow = r_rasUnderflow;
`else
  assign w_retTarget   = reg_target;
  assign ras_overflow  = 1'b0;
  assign ras_underflow = 1'b0;
`endif

  // Opcode decode: resolve taken/target and the link write for calls.
  always_comb begin
    w_nextPc = w_seq;
    w_taken  = 1'b0;
    w_linkPc = '0;
    w_linkWe = 1'b0;
    case (opcode)
      OpBnzBack: if (result != 32'd0) begin
        w_taken  = 1'b1;
        w_nextPc = w_seq - w_immPc;
      end
      OpBnzFwd: if (result != 32'd0) begin
        w_taken  = 1'b1;
        w_nextPc = w_seq + w_immPc;
      end
      OpBzA, OpBzB: if (result == 32'd0) begin
        w_taken  = 1'b1;
        w_nextPc = w_seq + w_immPc;
      end
      OpBoneA, OpBoneB: if (result == 32'd1) begin
        w_taken  = 1'b1;
        w_nextPc = w_seq + w_immPc;
      end
      OpJump: begin
        w_taken  = 1'b1;
        w_nextPc = address;
      end
      OpJumpReg: begin
        w_taken  = 1'b1;
        w_nextPc = w_retTarget;
      end
      OpCall: begin
        w_taken  = 1'b1;
        w_nextPc = address;
        w_linkPc = w_seq;
        w_linkWe = 1'b1;
      end
      default: ;
    endcase
  end

  // Response register: load on acceptance, hold until consumed, then drop the link write.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_outValid <= 1'b0;
      r_newPc    <= '0;
      r_taken    <= 1'b0;
      r_linkPc   <= '0;
      r_linkWe   <= 1'b0;
    end else if (w_accept) begin
      r_outValid <= 1'b1;
      r_newPc    <= w_nextPc;
      r_taken    <= w_taken;
      r_linkPc   <= w_linkPc;
      r_linkWe   <= w_linkWe;
    end else if (out_ready) begin
      r_outValid <= 1'b0;
      r_linkPc   <= '0;
      r_linkWe   <= 1'b0;
    end
  end

  assign out_valid = r_outValid;
  assign new_pc    = r_newPc;
  assign taken     = r_taken;
  assign link_pc   = r_linkPc;
  assign link_we   = r_linkWe;

endmodule

// File: tb/tb_next_pc_unit.sv
// Testbench for next_pc_unit: scoreboard queue filled at request acceptance,
// drained by an independent monitor. RAS scenarios build with NEXT_PC_RAS_EN.
module tb_next_pc_unit;

  localparam int PC_W      = 8;
  localparam int IMM_W     = 16;
  localparam int RAS_DEPTH = 4;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [PC_W-1:0]  pc = '0;
  logic [PC_W-1:0]  address = '0;
  logic [PC_W-1:0]  reg_target = '0;
  logic [5:0]       opcode = '0;
  logic [31:0]      result = '0;
  logic [IMM_W-1:0] imm = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [PC_W-1:0]  new_pc;
  logic             taken;
  logic [PC_W-1:0]  link_pc;
  logic             link_we;
  logic             ras_overflow;
  logic             ras_underflow;

  next_pc_unit #(.PC_W(PC_W), .IMM_W(IMM_W), .RAS_DEPTH(RAS_DEPTH)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .pc(pc), .address(address), .reg_target(reg_target), .opcode(opcode),
    .result(result), .imm(imm), .out_valid(out_valid), .out_ready(out_ready),
    .new_pc(new_pc), .taken(taken), .link_pc(link_pc), .link_we(link_we),
    .ras_overflow(ras_overflow), .ras_underflow(ras_underflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [PC_W-1:0] newPc;
    logic            taken;
    logic [PC_W-1:0] linkPc;
    logic            linkWe;
    logic            ovf;
    logic            unf;
  } exp_t;

  exp_t            expQ[$];
  logic [PC_W-1:0] rasModel[$];
  bit              modelOvf = 1'b0;
  bit              modelUnf = 1'b0;
  bit              monitorEn = 1'b1;
  bit              presented = 1'b0;
  exp_t            cur;
  int              checks = 0;
  int              errors = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: branch rules written directly as arithmetic, RAS as a queue.
  function automatic exp_t modelStep(input logic [PC_W-1:0] p, input logic [5:0] op,
                                     input logic [31:0] res, input logic [IMM_W-1:0] im,
                                     input logic [PC_W-1:0] addr, input logic [PC_W-1:0] rt);
    exp_t e;
    logic [PC_W-1:0] seq;
    logic [PC_W-1:0] immT;
    seq  = p + 8'd1;
    immT = im[PC_W-1:0];
    e.newPc = seq; e.taken = 1'b0; e.linkPc = '0; e.linkWe = 1'b0;
    case (op)
      6'b001110: if (res != 0) begin e.taken = 1'b1; e.newPc = seq - immT; end
      6'b001111: if (res != 0) begin e.taken = 1'b1; e.newPc = seq + immT; end
      6'b010000, 6'b010001: if (res == 0) begin e.taken = 1'b1; e.newPc = seq + immT; end
      6'b010010, 6'b010011: if (res == 1) begin e.taken = 1'b1; e.newPc = seq + immT; end
      6'b010100: begin e.taken = 1'b1; e.newPc = addr; end
      6'b010101: begin
        e.taken = 1'b1;
        e.newPc = rt;
`ifdef NEXT_PC_RAS_EN
        if (rasModel.size() == 0) modelUnf = 1'b1;
        else e.newPc = rasModel.pop_back();
`endif
      end
      6'b010110: begin
        e.taken = 1'b1; e.newPc = addr; e.linkPc = seq; e.linkWe = 1'b1;
`ifdef NEXT_PC_RAS_EN
        if (rasModel.size() == RAS_DEPTH) begin
          void'(rasModel.pop_front());
          modelOvf = 1'b1;
        end
        rasModel.push_back(seq);
`endif
      end
      default: ;
    endcase
    e.ovf = modelOvf;
    e.unf = modelUnf;
    return e;
  endfunction

  // One cycle of stimulus driven after the falling edge; acceptance is decided
  // from in_ready as seen before the next rising edge.
  task automatic applyStimulus(input bit v, input logic [PC_W-1:0] p, input logic [5:0] op,
                               input logic [31:0] res, input logic [IMM_W-1:0] im,
                               input logic [PC_W-1:0] addr, input logic [PC_W-1:0] rt,
                               input bit rdy, output bit acc);
    @(negedge clk);
    in_valid = v; pc = p; opcode = op; result = res; imm = im;
    address = addr; reg_target = rt; out_ready = rdy;
    #1;
    acc = in_valid && in_ready;
    if (acc) expQ.push_back(modelStep(p, op, res, im, addr, rt));
  endtask

  task automatic sendReq(input logic [PC_W-1:0] p, input logic [5:0] op, input logic [31:0] res,
                         input logic [IMM_W-1:0] im, input logic [PC_W-1:0] addr,
                         input logic [PC_W-1:0] rt);
    bit acc;
    acc = 1'b0;
    for (int i = 0; i < 20 && !acc; i++) applyStimulus(1'b1, p, op, res, im, addr, rt, 1'b1, acc);
    checkOutput("acceptTimeout", {31'd0, acc}, 32'd1);
  endtask

  task automatic idle(input int n, input bit rdy);
    bit acc;
    for (int i = 0; i < n; i++) applyStimulus(1'b0, '0, '0, '0, '0, '0, '0, rdy, acc);
  endtask

  // Monitor: compare each newly presented response with the scoreboard head,
  // and re-check it every cycle it is held.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (!monitorEn || !reset) begin
        presented = 1'b0;
        continue;
      end
      if (out_valid && !presented) begin
        if (expQ.size() == 0) begin
          checks++; errors++;
          $display("[TB] FAIL unexpectedResponse: got new_pc %0h required none", new_pc);
        end else begin
          cur = expQ.pop_front();
          presented = 1'b1;
          checkOutput("newPc", {24'd0, new_pc}, {24'd0, cur.newPc});
          checkOutput("taken", {31'd0, taken}, {31'd0, cur.taken});
          checkOutput("linkPc", {24'd0, link_pc}, {24'd0, cur.linkPc});
          checkOutput("linkWe", {31'd0, link_we}, {31'd0, cur.linkWe});
          checkOutput("rasOverflow", {31'd0, ras_overflow}, {31'd0, cur.ovf});
          checkOutput("rasUnderflow", {31'd0, ras_underflow}, {31'd0, cur.unf});
        end
      end else if (out_valid && presented) begin
        checkOutput("holdNewPc", {24'd0, new_pc}, {24'd0, cur.newPc});
        checkOutput("holdTaken", {31'd0, taken}, {31'd0, cur.taken});
        checkOutput("holdLinkWe", {31'd0, link_we}, {31'd0, cur.linkWe});
      end else begin
        checkOutput("idleLinkWe", {31'd0, link_we}, 32'd0);
      end
      if (out_valid && out_ready) presented = 1'b0;
    end
  end

  logic [5:0] opList [10] = '{6'h0E, 6'h0F, 6'h10, 6'h11, 6'h12, 6'h13, 6'h14, 6'h15, 6'h16, 6'h00};

  initial begin
    bit acc;
    logic [31:0] res;
    int waitCnt;

    // Reset state while reset is held low
    @(negedge clk); #1;
    checkOutput("rstOutValid", {31'd0, out_valid}, 32'd0);
    checkOutput("rstNewPc", {24'd0, new_pc}, 32'd0);
    checkOutput("rstInReady", {31'd0, in_ready}, 32'd1);
    checkOutput("rstOverflow", {31'd0, ras_overflow}, 32'd0);
    checkOutput("rstUnderflow", {31'd0, ras_underflow}, 32'd0);
    #2 reset = 1'b1;

    // Backward branch and wrap-around forward branch
    sendReq(8'h10, 6'b001110, 32'd5, 16'd3, 8'h00, 8'h00);
    sendReq(8'hFF, 6'b001111, 32'd1, 16'd2, 8'h00, 8'h00);
    sendReq(8'hFF, 6'b001111, 32'd0, 16'd2, 8'h00, 8'h00);
    idle(2, 1'b1);

    // Back-pressure: response held three cycles, new request refused meanwhile
    applyStimulus(1'b1, 8'h40, 6'b010100, 32'd0, 16'd0, 8'hA5, 8'h00, 1'b0, acc);
    checkOutput("stallFirstAccept", {31'd0, acc}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 8'h50, 6'b010000, 32'd0, 16'd4, 8'h00, 8'h00, 1'b0, acc);
      checkOutput("stallAccept", {31'd0, acc}, 32'd0);
      checkOutput("stallInReady", {31'd0, in_ready}, 32'd0);
    end
    applyStimulus(1'b1, 8'h50, 6'b010000, 32'd0, 16'd4, 8'h00, 8'h00, 1'b1, acc);
    checkOutput("stallRelease", {31'd0, acc}, 32'd1);
    idle(2, 1'b1);

`ifdef NEXT_PC_RAS_EN
    // Call then return through the stack
    sendReq(8'h20, 6'b010110, 32'd0, 16'd0, 8'h80, 8'h00);
    sendReq(8'h80, 6'b010101, 32'd0, 16'd0, 8'h00, 8'h55);
    idle(2, 1'b1);
    // Overflow by one extra call, then underflow by one extra return
    for (int i = 0; i <= RAS_DEPTH; i++)
      sendReq(8'(8'h30 + i), 6'b010110, 32'd0, 16'd0, 8'hC0, 8'h00);
    for (int i = 0; i <= RAS_DEPTH; i++)
      sendReq(8'hC0, 6'b010101, 32'd0, 16'd0, 8'h00, 8'(8'h60 + i));
    idle(2, 1'b1);
    checkOutput("stickyOverflow", {31'd0, ras_overflow}, 32'd1);
    checkOutput("stickyUnderflow", {31'd0, ras_underflow}, 32'd1);
`endif

    // Randomized traffic with random back-pressure
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 2))
        0: res = 32'd0;
        1: res = 32'd1;
        default: res = $urandom;
      endcase
      applyStimulus(($urandom_range(0, 9) < 7), 8'($urandom), 
                    ($urandom_range(0, 9) == 9) ? 6'($urandom) : opList[$urandom_range(0, 9)],
                    res, 16'($urandom), 8'($urandom), 8'($urandom),
                    ($urandom_range(0, 9) < 6), acc);
    end

    // Drain the scoreboard with a bounded wait
    waitCnt = 0;
    while ((expQ.size() != 0 || out_valid) && waitCnt < 50) begin
      idle(1, 1'b1);
      waitCnt++;
    end
    checkOutput("drainPending", expQ.size(), 32'd0);

    // Asynchronous reset while a response is being held
    applyStimulus(1'b1, 8'h20, 6'b010110, 32'd0, 16'd0, 8'h90, 8'h00, 1'b0, acc);
    idle(1, 1'b0);
    @(negedge clk); #3;
    monitorEn = 1'b0;
    checkOutput("preResetValid", {31'd0, out_valid}, 32'd1);
    reset = 1'b0;
    out_ready = 1'b1;
    #1;
    checkOutput("asyncOutValid", {31'd0, out_valid}, 32'd0);
    checkOutput("asyncNewPc", {24'd0, new_pc}, 32'd0);
    checkOutput("asyncTaken", {31'd0, taken}, 32'd0);
    checkOutput("asyncLinkPc", {24'd0, link_pc}, 32'd0);
    checkOutput("asyncLinkWe", {31'd0, link_we}, 32'd0);
    checkOutput("asyncOverflow", {31'd0, ras_overflow}, 32'd0);
    checkOutput("asyncUnderflow", {31'd0, ras_underflow}, 32'd0);
    checkOutput("asyncInReady", {31'd0, in_ready}, 32'd1);
    expQ.delete();
    rasModel.delete();
    modelOvf = 1'b0;
    modelUnf = 1'b0;
    @(negedge clk); #3;
    reset = 1'b1;
    monitorEn = 1'b1;
    idle(2, 1'b1);
    checkOutput("postResetValid", {31'd0, out_valid}, 32'd0);
    sendReq(8'h10, 6'b001110, 32'd5, 16'd3, 8'h00, 8'h00);
    idle(3, 1'b1);
    checkOutput("finalPending", expQ.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
